// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring divider. It produces one quotient bit per clock and
//   uses a start/done handshake, so the MAC control logic can issue
//   normalisation and scaling divides without a combinational divider array.
//
//   Latency: done pulses WIDTH+1 clocks after the edge that accepts start.
//   A zero divisor pulses done 1 clock after that edge.
//
//   Optional build macro:
//     SEQ_DIVIDER_SIGNED_EN - operands are two's complement. The quotient
//                             truncates toward zero and the remainder takes
//                             the sign of the dividend. When the macro is
//                             undefined, arithmetic is unsigned and no sign
//                             logic is built.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   start        request pulse, sampled only while idle
//   dividend     numerator, captured when start is accepted
//   divisor      denominator, captured when start is accepted
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse; results are valid
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered zero-divisor flag, updated with done
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;        // quotient shift register
  logic [WIDTH-1:0] d_q, d_d;        // captured divisor magnitude
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder, always < divisor
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;      // current operation hit a zero divisor
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // The stored remainder stays below the divisor, so its top bit is always
  // zero. Only the shifted value and the trial difference need WIDTH+1 bits,
  // and bit WIDTH of the trial is the borrow that decides the quotient bit.
  logic [WIDTH:0]   r_shift, trial;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] zero_div_quot;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q,  neg_rem_d;

  assign dividend_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
  // x / 0 yields -1 for a non-negative dividend and +1 for a negative one.
  assign zero_div_quot = dividend[WIDTH-1] ? WIDTH'(1) : '1;
`else
  assign dividend_mag  = dividend;
  assign divisor_mag   = divisor;
  assign zero_div_quot = '1;
`endif

  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_q};

  // NOTE: every variable in this block is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // The final results are preloaded here, and DONE publishes them
            // unchanged.
            q_d     = zero_div_quot;
            r_d     = dividend;
            d_d     = '0;
            cnt_d   = '0;
            dz_d    = 1'b1;
            state_d = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
`endif
          end else begin
            q_d     = dividend_mag;
            d_d     = divisor_mag;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
`endif
          end
        end
      end

      RUN: begin
        // One restoring step: shift {R,Q} left, then keep R - D if it does
        // not borrow.
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        quot_d = neg_quot_q ? -q_q : q_q;
        rem_d  = neg_rem_q  ? -r_q : r_q;
`else
        quot_d = q_q;
        rem_d  = r_q;
`endif
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control registers, because an abandoned operation must also clear the visible results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values from before this edge.
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider with WIDTH = 32. Directed scenarios
//   and randomized operands are compared against a plain arithmetic reference
//   model. Define SEQ_DIVIDER_SIGNED_EN for both the bench and the RTL when
//   testing the signed build.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed directly from the arithmetic definition.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (b == 0) begin
      dz = 1'b1;
      q  = ($signed(a) < 0) ? 32'd1 : 32'hFFFF_FFFF;
      r  = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      dz = 1'b0;
      q  = 32'h8000_0000;
      r  = 32'd0;
    end else begin
      dz = 1'b0;
      q  = $signed(a) / $signed(b);
      r  = $signed(a) % $signed(b);
    end
`else
    if (b == 0) begin
      dz = 1'b1;
      q  = 32'hFFFF_FFFF;
      r  = a;
    end else begin
      dz = 1'b0;
      q  = a / b;
      r  = a % b;
    end
`endif
  endfunction

  // Issues one operation from the post-edge sampling point and returns at
  // the sample where done is seen. lat counts edges from the start-accepting
  // edge (-1 on timeout). busy_ok reports whether busy was high at every
  // sample before done and low at the done sample.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_ok);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = -1;
    busy_ok  = busy && !done;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    logic bok;
    run_op(32'd100, 32'd7, lat, bok);
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
    n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", bok); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got=%b exp=0", done); end
  endtask

  task automatic test_zero_div();
    int lat;
    logic bok;
    run_op(32'd5, 32'd0, lat, bok);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zdiv_latency got=%0d exp=1", lat); end
    n_checks++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL zdiv_quotient got=%h exp=ffffffff", quotient); end
    n_checks++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL zdiv_remainder got=%h exp=5", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL zdiv_dbz got=%b exp=1", div_by_zero); end
    run_op(32'd9, 32'd3, lat, bok);
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL zdiv_next_latency got=%0d exp=%0d", lat, W + 1); end
    n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL zdiv_next_quotient got=%0d exp=3", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL zdiv_next_remainder got=%0d exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL zdiv_next_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_extremes();
    logic [W-1:0] a_tab [3] = '{32'hFFFF_FFFF, 32'd3, 32'd0};
    logic [W-1:0] b_tab [3] = '{32'd1, 32'd10, 32'hFFFF_FFFF};
    logic [W-1:0] q_tab [3] = '{32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [W-1:0] r_tab [3] = '{32'd0, 32'd3, 32'd0};
    int lat;
    logic bok;
    for (int i = 0; i < 3; i++) begin
      run_op(a_tab[i], b_tab[i], lat, bok);
      n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL extreme%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
      n_checks++; if (quotient !== q_tab[i]) begin n_fail++; $display("FAIL extreme%0d_quotient got=%h exp=%h", i, quotient, q_tab[i]); end
      n_checks++; if (remainder !== r_tab[i]) begin n_fail++; $display("FAIL extreme%0d_remainder got=%h exp=%h", i, remainder, r_tab[i]); end
    end
  endtask

  task automatic test_handshake();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    start    = 1'b1;
    dividend = 32'd1234567;
    divisor  = 32'd89;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end else if (k == 10) begin
        start = 1'b0;
      end
      if (done) begin
        first_done = k;
        break;
      end
    end
    n_checks++; if (first_done != W + 1) begin n_fail++; $display("FAIL hs_first_latency got=%0d exp=%0d", first_done, W + 1); end
    n_checks++; if (quotient !== 32'd13871) begin n_fail++; $display("FAIL hs_first_quotient got=%0d exp=13871", quotient); end
    n_checks++; if (remainder !== 32'd48) begin n_fail++; $display("FAIL hs_first_remainder got=%0d exp=48", remainder); end
    // Start in the cycle after done, i.e. while done is still visible.
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd8;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        second_done = k;
        break;
      end
    end
    n_checks++; if (second_done != W + 2) begin n_fail++; $display("FAIL hs_b2b_spacing got=%0d exp=%0d", second_done, W + 2); end
    n_checks++; if (quotient !== 32'd9) begin n_fail++; $display("FAIL hs_second_quotient got=%0d exp=9", quotient); end
    n_checks++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL hs_second_remainder got=%0d exp=5", remainder); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic bok;
    logic saw_done;
    start    = 1'b1;
    dividend = 32'd12345678;
    divisor  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL midrst_quotient got=%h exp=0", quotient); end
    n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL midrst_remainder got=%h exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_dbz got=%b exp=0", div_by_zero); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_abandoned got=%b exp=0", saw_done); end
    run_op(32'd1000, 32'd33, lat, bok);
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL midrst_next_latency got=%0d exp=%0d", lat, W + 1); end
    n_checks++; if (quotient !== 32'd30) begin n_fail++; $display("FAIL midrst_next_quotient got=%0d exp=30", quotient); end
    n_checks++; if (remainder !== 32'd10) begin n_fail++; $display("FAIL midrst_next_remainder got=%0d exp=10", remainder); end
  endtask

  task automatic test_signed_option();
    int lat;
    logic bok;
    run_op(32'hFFFF_FFF9, 32'd2, lat, bok);
`ifdef SEQ_DIVIDER_SIGNED_EN
    n_checks++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sgn_neg7_quotient got=%h exp=fffffffd", quotient); end
    n_checks++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sgn_neg7_remainder got=%h exp=ffffffff", remainder); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL sgn_ovf_latency got=%0d exp=%0d", lat, W + 1); end
    n_checks++; if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL sgn_ovf_quotient got=%h exp=80000000", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL sgn_ovf_remainder got=%h exp=0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL sgn_ovf_dbz got=%b exp=0", div_by_zero); end
    run_op(32'hFFFF_FFF0, 32'd0, lat, bok);
    n_checks++; if (quotient !== 32'd1) begin n_fail++; $display("FAIL sgn_zdiv_quotient got=%h exp=1", quotient); end
    n_checks++; if (remainder !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL sgn_zdiv_remainder got=%h exp=fffffff0", remainder); end
`else
    n_checks++; if (quotient !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL uns_neg7_quotient got=%h exp=7ffffffc", quotient); end
    n_checks++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL uns_neg7_remainder got=%h exp=1", remainder); end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic         edz;
    logic [63:0]  recon;
    int           lat;
    logic         bok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(a, b, eq, er, edz);
      run_op(a, b, lat, bok);
      n_checks++; if (lat != (edz ? 1 : W + 1)) begin n_fail++; $display("FAIL rand%0d_latency a=%h b=%h got=%0d exp=%0d", i, a, b, lat, edz ? 1 : W + 1); end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_busy a=%h b=%h got=%b exp=1", i, a, b, bok); end
      n_checks++; if (quotient !== eq) begin n_fail++; $display("FAIL rand%0d_quotient a=%h b=%h got=%h exp=%h", i, a, b, quotient, eq); end
      n_checks++; if (remainder !== er) begin n_fail++; $display("FAIL rand%0d_remainder a=%h b=%h got=%h exp=%h", i, a, b, remainder, er); end
      n_checks++; if (div_by_zero !== edz) begin n_fail++; $display("FAIL rand%0d_dbz a=%h b=%h got=%b exp=%b", i, a, b, div_by_zero, edz); end
`ifndef SEQ_DIVIDER_SIGNED_EN
      if (!edz) begin
        recon = 64'(quotient) * 64'(b) + 64'(remainder);
        n_checks++; if (recon !== 64'(a) || remainder >= b) begin n_fail++; $display("FAIL rand%0d_invariant a=%h b=%h got_q=%h got_r=%h", i, a, b, quotient, remainder); end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_div();
    test_extremes();
    test_handshake();
    test_reset_mid_run();
    test_signed_option();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider. It is the inverse of the multiplier datapath: the MAC unit multiplies, and this block divides.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Uses a start/done handshake so the MAC control logic can issue normalisation and scaling divides without a combinational array.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (even, >= 4).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient; held until next done.
- remainder  output  WIDTH  registered remainder; held until next done.
- div_by_zero  output  1  registered flag for the last operation; updated with done.

Behaviour:
- One clock; reset is synchronous, active-low on rst_n.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, counter=0.
- States: IDLE, RUN, DONE.
- IDLE with start=1, divisor!=0:
  - capture dividend into Q shift register and divisor into D;
  - clear partial remainder R (WIDTH+1 bits);
  - set counter=WIDTH; go to RUN.
- IDLE with start=1, divisor==0:
  - go to DONE directly;
  - result: quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN, one step per cycle:
  - {R,Q} shifted left 1;
  - trial T = R - {0,D};
  - if T non-negative, R=T and Q[0]=1; else R unchanged and Q[0]=0;
  - counter decrements; on the cycle counter reaches 0, go to DONE.
- DONE: register quotient=Q and remainder=R[WIDTH-1:0], div_by_zero=0 (except the zero-divisor path); done=1 for exactly this cycle; next state IDLE.
- Latency:
  - done asserts WIDTH+1 cycles after the start-sampling edge (33 for WIDTH=32);
  - zero-divisor path asserts done 1 cycle after.
- busy is 1 in RUN and DONE, 0 in IDLE. A new start is accepted in the cycle after done (back-to-back throughput WIDTH+2 cycles).
- start while busy is ignored (no queueing, no corruption).
- Operand inputs are don't-care outside the start-sampling cycle.
- Reset mid-operation: the operation is abandoned, no done pulse, and all outputs return to reset values on that edge.
- Arithmetic is unsigned (without the option below).
- Invariant checked on every done with div_by_zero=0: dividend == quotient*divisor + remainder and remainder < divisor.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - IDLE captures absolute values and stores sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - DONE negates quotient if sign_q and remainder if sign_r, giving truncation toward zero; the remainder sign follows the dividend.
  - Most-negative / -1 returns quotient = most-negative, remainder = 0 (wraps, no flag).
  - Divide by zero returns quotient = -1 if dividend >= 0, else +1; remainder = dividend; div_by_zero=1.
  - Latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesised.

Test Plan:
- Basic divide: start with 100 / 7 → done exactly 33 cycles after the start edge, quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1..33.
- Zero divisor: 5 / 0 → done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; then 9 / 3 → quotient=3, remainder=0, div_by_zero=0.
- Extremes:
  - 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0;
  - 3 / 10 → quotient=0, remainder=3;
  - 0 / 0xFFFFFFFF → quotient=0, remainder=0.
- Handshake: pulse start with 50 / 5 at cycle 10 after the first start → ignored, first result unchanged; start in the cycle after done → accepted, second done 34 cycles after the first done.
- Reset mid-run: rst_n low at cycle 15 of a RUN → next edge busy=0, quotient=0, remainder=0, no done pulse; a subsequent 1000 / 33 → quotient=30, remainder=10.
- Signed option, -7 / 2 (0xFFFFFFF9 / 2):
  - with SEQ_DIVIDER_SIGNED_EN: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
  - without it: quotient=0x7FFFFFFC, remainder=1;
  - with it, 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
